// File: rtl/fabric_ingress_arbiter.sv
// rtl/fabric_ingress_arbiter.sv - frame-granular round-robin arbiter for the shared line-card ingress stream
// Grants one port FIFO at a time, holds it to end of frame, and reclaims the stream on a runaway frame.
module fabric_ingress_arbiter #(
  parameter int NUM_PORTS        = 24,
  parameter int FRAMES_PER_GRANT = 1,
  parameter int MAX_BEATS        = 1200
) (
  input  logic                         clk_fabric,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]         grant,
  output logic                         grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  input  logic                         beat_valid,
  input  logic                         beat_ready,
  input  logic                         beat_last,
  output logic                         abort,
  output logic                         timeout_err,
  output logic [$clog2(NUM_PORTS)-1:0] timeout_port
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [3:0]    FPG       = 4'(FRAMES_PER_GRANT);
  localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_after;
  logic [CW-1:0] beat_cnt;
  logic [3:0]    frames_left;
  logic          xfer;
  logic [IW:0]   idle_pick;
  logic [IW:0]   next_pick;

  // Returns {found, index} of the first set bit at or after start, wrapping.
  function automatic logic [IW:0] pick(input logic [NUM_PORTS-1:0] r, input logic [IW-1:0] start);
    logic [IW:0] res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = {1'b0, start} + PW'(i);
      if (idx >= PW'(NUM_PORTS)) idx = idx - PW'(NUM_PORTS);
      if (r[idx[IW-1:0]]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Reset asserts asynchronously and releases synchronously to clk_fabric.
  always_ff @(posedge clk_fabric or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign xfer      = beat_valid & beat_ready;
  assign ptr_after = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
  assign idle_pick = pick(req, ptr);
  // The finishing port may still show req for a cycle, so it is excluded from the handoff.
  assign next_pick = pick(req & ~grant, ptr_after);

  always_ff @(posedge clk_fabric or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= IDLE;
      ptr          <= '0;
      beat_cnt     <= '0;
      frames_left  <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      abort        <= 1'b0;
      timeout_err  <= 1'b0;
      timeout_port <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_pick[IW]) begin
            state       <= BUSY;
            grant_idx   <= idle_pick[IW-1:0];
            grant       <= onehot(idle_pick[IW-1:0]);
            grant_valid <= 1'b1;
            frames_left <= FPG;
            beat_cnt    <= '0;
          end
        end
        BUSY: begin
          if (xfer && beat_last) begin
            beat_cnt <= '0;
            if (frames_left != 4'd1 && req[grant_idx]) begin
              frames_left <= frames_left - 4'd1;
            end else begin
              ptr <= ptr_after;
              if (next_pick[IW]) begin
                grant_idx   <= next_pick[IW-1:0];
                grant       <= onehot(next_pick[IW-1:0]);
                frames_left <= FPG;
              end else begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
              end
            end
          end else if (xfer) begin
            if (beat_cnt == WDOG_LAST) begin
              state        <= ABORT;
              abort        <= 1'b1;
              timeout_err  <= 1'b1;
              timeout_port <= grant_idx;
              beat_cnt     <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ABORT: begin
          if (xfer && beat_last) begin
            state       <= IDLE;
            abort       <= 1'b0;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= ptr_after;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
